// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control sequencer.
//   state_t      : sequencer states
//   OP_*         : decoded instruction[31:26] encodings
//   ALUOP_*      : ALU operation class driven on alu_op
//   ctrl_t       : the eight datapath strobes produced by mips_ctrl_decode
//   is_known_op  : true for the opcodes this sequencer executes
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       mem_to_reg;  // 1 = ALU result, 0 = memory data
    logic       pc_src;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    logic known;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: known = 1'b1;
      default:                                 known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational strobe decode for the multicycle MIPS sequencer.
//   state : current sequencer state
//   op    : opcode latched in DECODE
//   zero  : ALU zero flag (only meaningful in EXEC)
//   ctrl  : datapath strobes; all zero outside EXEC/MEM/WB
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      EXEC: begin
        case (op)
          OP_RTYPE: ctrl.alu_op = ALUOP_FUNCT;
          OP_LW, OP_SW, OP_ADDI: begin
            ctrl.alu_src = 1'b1;
            ctrl.alu_op  = ALUOP_ADD;
          end
          OP_BEQ: begin
            ctrl.alu_op = ALUOP_SUB;
            ctrl.pc_src = zero;
          end
          default: ;
        endcase
      end
      MEM: begin
        ctrl.mem_read  = (op == OP_LW);
        ctrl.mem_write = (op == OP_SW);
      end
      WB: begin
        ctrl.reg_write = 1'b1;
        case (op)
          OP_RTYPE: begin
            ctrl.reg_dst    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
          end
          OP_ADDI: ctrl.mem_to_reg = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle control sequencer for the single-issue MIPS datapath.
// Steps IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and decodes the
// datapath strobes from the state and the opcode latched in DECODE.
//   clk, rst      : core clock; asynchronous active-low reset
//   run           : level, permits leaving IDLE / starting the next fetch
//   opcode, funct : instruction fields, captured in DECODE
//   zero          : ALU zero flag (EXEC), mem_ready : data memory done (MEM)
//   pc_write, ir_write, reg_write, reg_dst, mem_read, mem_write, alu_src,
//   mem_to_reg, pc_src, alu_op : datapath controls
//   instr_done    : pulse on the last state of every instruction
//   trap          : sticky illegal-opcode / memory-timeout flag
// Optional build macro MIPS_CTRL_PERF_EN adds cycle_cnt and instr_cnt.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W    = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                trap
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instr_cnt
`endif
);

  localparam int unsigned      CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic [5:0]       funct_q;
  logic [CNT_W-1:0] wait_q;
  ctrl_t            ctrl;
  state_t           after_done;

  // funct is held for the ALU-control stage; this block never consumes it.
  logic unused_funct;
  assign unused_funct = ^funct_q;

  mips_ctrl_decode u_decode (
    .state (state_q),
    .op    (op_q),
    .zero  (zero),
    .ctrl  (ctrl)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      funct_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
      // On the final stalled cycle the counter reaches MEM_TIMEOUT on the
      // same edge that moves the FSM into TRAP.
      if (state_q == MEM) begin
        if (mem_ready) wait_q <= '0;
        else           wait_q <= wait_q + 1'b1;
      end
    end
  end

  always_comb begin
    after_done = run ? FETCH : IDLE;
    state_d    = state_q;
    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: state_d = is_known_op(opcode) ? EXEC : TRAP;
      EXEC: begin
        case (op_q)
          OP_BEQ:       state_d = after_done;
          OP_LW, OP_SW: state_d = MEM;
          default:      state_d = WB;
        endcase
      end
      MEM: begin
        if (mem_ready)              state_d = (op_q == OP_LW) ? WB : after_done;
        else if (wait_q == WAIT_LAST) state_d = TRAP;
      end
      WB:     state_d = after_done;
      TRAP:   state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_write  = ctrl.reg_write;
    reg_dst    = ctrl.reg_dst;
    mem_read   = ctrl.mem_read;
    mem_write  = ctrl.mem_write;
    alu_src    = ctrl.alu_src;
    mem_to_reg = ctrl.mem_to_reg;
    pc_src     = ctrl.pc_src;
    alu_op     = ALU_OP_W'(ctrl.alu_op);
    ir_write   = (state_q == FETCH);
    pc_write   = (state_q == FETCH) ||
                 ((state_q == EXEC) && (op_q == OP_BEQ) && zero);
    instr_done = ((state_q == EXEC) && (op_q == OP_BEQ)) ||
                 ((state_q == MEM) && (op_q == OP_SW) && mem_ready) ||
                 (state_q == WB);
    trap       = (state_q == TRAP);
  end

`ifdef MIPS_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if ((state_q != IDLE) && (state_q != TRAP)) cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done)                             instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write, reg_dst, mem_read, mem_write;
  logic       alu_src, mem_to_reg, pc_src, instr_done, trap;
  logic [1:0] alu_op;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // {pc_write, ir_write, reg_write, reg_dst, mem_read, mem_write, alu_src,
  //  mem_to_reg, pc_src, alu_op[1:0], instr_done, trap}
  localparam logic [12:0] O_NONE  = 13'b0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] O_FETCH = 13'b1_1_0_0_0_0_0_0_0_00_0_0;
  localparam logic [12:0] X_R     = 13'b0_0_0_0_0_0_0_0_0_10_0_0;
  localparam logic [12:0] X_I     = 13'b0_0_0_0_0_0_1_0_0_00_0_0;
  localparam logic [12:0] W_R     = 13'b0_0_1_1_0_0_0_1_0_00_1_0;
  localparam logic [12:0] W_A     = 13'b0_0_1_0_0_0_0_1_0_00_1_0;
  localparam logic [12:0] W_L     = 13'b0_0_1_0_0_0_0_0_0_00_1_0;
  localparam logic [12:0] M_L     = 13'b0_0_0_0_1_0_0_0_0_00_0_0;
  localparam logic [12:0] M_S     = 13'b0_0_0_0_0_1_0_0_0_00_0_0;
  localparam logic [12:0] M_SD    = 13'b0_0_0_0_0_1_0_0_0_00_1_0;
  localparam logic [12:0] B_T     = 13'b1_0_0_0_0_0_0_0_1_01_1_0;
  localparam logic [12:0] B_N     = 13'b0_0_0_0_0_0_0_0_0_01_1_0;
  localparam logic [12:0] O_TRAP  = 13'b0_0_0_0_0_0_0_0_0_00_0_1;

  mips_mc_ctrl #(.ALU_OP_W(2), .MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .trap       (trap)
`ifdef MIPS_CTRL_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] outs();
    return {pc_write, ir_write, reg_write, reg_dst, mem_read, mem_write,
            alu_src, mem_to_reg, pc_src, alu_op, instr_done, trap};
  endfunction

  task automatic test_reset();
    rst = 1'b0; run = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (outs() !== O_NONE) begin
      $display("FAIL reset_hold: got %b want %b", outs(), O_NONE); n_miss++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (outs() !== O_NONE) begin
        $display("FAIL idle_no_run cyc %0d: got %b want %b", i, outs(), O_NONE); n_miss++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    logic [12:0] e [0:5];
    e = '{O_NONE, O_FETCH, O_NONE, X_R, W_R, O_NONE};
    opcode = 6'h00;
    for (int i = 0; i < 6; i++) begin
      run = (i == 0);
      #1;
      n_vec++;
      if (outs() !== e[i]) begin
        $display("FAIL rtype cyc %0d: got %b want %b", i, outs(), e[i]); n_miss++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_addi();
    logic [12:0] e [0:5];
    e = '{O_NONE, O_FETCH, O_NONE, X_I, W_A, O_NONE};
    opcode = 6'h08;
    for (int i = 0; i < 6; i++) begin
      run = (i == 0);
      #1;
      n_vec++;
      if (outs() !== e[i]) begin
        $display("FAIL addi cyc %0d: got %b want %b", i, outs(), e[i]); n_miss++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_stall();
    logic [12:0] e [0:9];
    e = '{O_NONE, O_FETCH, O_NONE, X_I, M_L, M_L, M_L, M_L, W_L, O_NONE};
    opcode = 6'h23;
    for (int i = 0; i < 10; i++) begin
      run = (i == 0);
      mem_ready = (i == 7);
      #1;
      n_vec++;
      if (outs() !== e[i]) begin
        $display("FAIL lw_stall cyc %0d: got %b want %b", i, outs(), e[i]); n_miss++;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_sw();
    logic [12:0] e [0:5];
    e = '{O_NONE, O_FETCH, O_NONE, X_I, M_SD, O_NONE};
    opcode = 6'h2B;
    for (int i = 0; i < 6; i++) begin
      run = (i == 0);
      mem_ready = (i == 4);
      #1;
      n_vec++;
      if (outs() !== e[i]) begin
        $display("FAIL sw cyc %0d: got %b want %b", i, outs(), e[i]); n_miss++;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_beq(input logic z);
    logic [12:0] e [0:4];
    e = '{O_NONE, O_FETCH, O_NONE, (z ? B_T : B_N), O_NONE};
    opcode = 6'h04;
    zero = z;
    for (int i = 0; i < 5; i++) begin
      run = (i == 0);
      #1;
      n_vec++;
      if (outs() !== e[i]) begin
        $display("FAIL beq_z%0d cyc %0d: got %b want %b", z, i, outs(), e[i]); n_miss++;
      end
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [12:0] e [0:9];
    e = '{O_NONE, O_FETCH, O_NONE, X_R, W_R, O_FETCH, O_NONE, X_I, W_A, O_NONE};
    for (int i = 0; i < 10; i++) begin
      run = (i < 5);
      opcode = (i < 5) ? 6'h00 : 6'h08;
      #1;
      n_vec++;
      if (outs() !== e[i]) begin
        $display("FAIL back_to_back cyc %0d: got %b want %b", i, outs(), e[i]); n_miss++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_trap();
    logic [12:0] want;
    opcode = 6'h3F;
    zero = 1'b1;
    for (int i = 0; i < 23; i++) begin
      run = 1'b1;
      mem_ready = (i % 2 == 1);
      want = (i == 1) ? O_FETCH : ((i >= 3) ? O_TRAP : O_NONE);
      #1;
      n_vec++;
      if (outs() !== want) begin
        $display("FAIL illegal_trap cyc %0d: got %b want %b", i, outs(), want); n_miss++;
      end
      @(negedge clk);
    end
    zero = 1'b0; mem_ready = 1'b0; run = 1'b0;
    rst = 1'b0;
    #1;
    n_vec++;
    if (outs() !== O_NONE) begin
      $display("FAIL trap_clear_rst: got %b want %b", outs(), O_NONE); n_miss++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (outs() !== O_NONE) begin
      $display("FAIL trap_idle_after_rst: got %b want %b", outs(), O_NONE); n_miss++;
    end
    @(negedge clk);
  endtask

  task automatic test_mem_timeout();
    logic [12:0] want;
    opcode = 6'h2B;
    // Ready arrives on the 15th MEM cycle: completes normally.
    for (int i = 0; i < 20; i++) begin
      run = (i == 0);
      mem_ready = (i == 18);
      case (i)
        0, 2, 19: want = O_NONE;
        1:        want = O_FETCH;
        3:        want = X_I;
        18:       want = M_SD;
        default:  want = M_S;
      endcase
      #1;
      n_vec++;
      if (outs() !== want) begin
        $display("FAIL sw_ready_last cyc %0d: got %b want %b", i, outs(), want); n_miss++;
      end
      @(negedge clk);
    end
    // Ready never arrives: 15 MEM cycles then TRAP.
    for (int i = 0; i < 21; i++) begin
      run = (i == 0);
      mem_ready = 1'b0;
      case (i)
        0, 2:    want = O_NONE;
        1:       want = O_FETCH;
        3:       want = X_I;
        19, 20:  want = O_TRAP;
        default: want = M_S;
      endcase
      #1;
      n_vec++;
      if (outs() !== want) begin
        $display("FAIL sw_timeout cyc %0d: got %b want %b", i, outs(), want); n_miss++;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (outs() !== O_NONE) begin
      $display("FAIL timeout_rst_recover: got %b want %b", outs(), O_NONE); n_miss++;
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset_mem();
    logic [12:0] e [0:4];
    e = '{O_NONE, O_FETCH, O_NONE, X_I, M_L};
    opcode = 6'h23;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run = (i == 0);
      #1;
      n_vec++;
      if (outs() !== e[i]) begin
        $display("FAIL lw_pre_reset cyc %0d: got %b want %b", i, outs(), e[i]); n_miss++;
      end
      if (i < 4) @(negedge clk);
    end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (outs() !== O_NONE) begin
      $display("FAIL async_rst_immediate: got %b want %b", outs(), O_NONE); n_miss++;
    end
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (outs() !== O_NONE) begin
        $display("FAIL no_wb_after_rst cyc %0d: got %b want %b", i, outs(), O_NONE); n_miss++;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_addi();
    test_lw_stall();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_back_to_back();
    test_illegal_trap();
    test_mem_timeout();
    test_async_reset_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

endmodule
